// File: rtl/mult_arb_pkg.sv
// Shared types and helpers for the multiplier arbiter: FSM state encoding,
// default operand widths and an index-width helper.
package mult_arb_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LAUNCH    = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    RESP      = 3'd4
  } arb_state_e;

  localparam int MBITS_DEF = 16;
  localparam int NBITS_DEF = 16;

  // Index width for n items; never less than one bit.
  function automatic int idw(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mult_arbiter_rr_pick.sv
// Combinational round-robin select: first set request at or after ptr,
// wrapping from NREQ-1 back to 0.
module rr_pick
  import mult_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = idw(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] win,
  output logic [IW-1:0]   win_id,
  output logic            any
);

  logic [IW-1:0] sel;

  always_comb begin
    win    = '0;
    win_id = '0;
    any    = 1'b0;
    sel    = '0;
    for (int k = 0; k < NREQ; k++) begin
      sel = IW'((int'(ptr) + k) % NREQ);
      if (!any && req[sel]) begin
        any      = 1'b1;
        win[sel] = 1'b1;
        win_id   = sel;
      end
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin front end sharing one sequential multiplier among NREQ clients;
// grants one request at a time and returns the tagged product or a timeout.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | multiplier free: pick a winner, latch operands, pulse gnt
// LAUNCH    | register mult_start for one cycle, arm the watchdog
// WAIT_BUSY | waiting for the multiplier to raise busy
// WAIT_DONE | waiting for busy to fall, then capture the product
// RESP      | rsp_valid pulse; response fields hold afterwards
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int MBITS   = MBITS_DEF,
  parameter int NBITS   = NBITS_DEF,
  parameter int TIMEOUT = 63
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*MBITS-1:0]    req_mpd,
  input  logic [NREQ*NBITS-1:0]    req_mpr,
  output logic [NREQ-1:0]          gnt,
  output logic                     rsp_valid,
  output logic [idw(NREQ)-1:0]     rsp_id,
  output logic [MBITS+NBITS-1:0]   rsp_prod,
  output logic                     rsp_err,
  output logic [MBITS-1:0]         mult_mpd,
  output logic [NBITS-1:0]         mult_mpr,
  output logic                     mult_start,
  input  logic                     mult_busy,
  input  logic [MBITS+NBITS-1:0]   mult_prod
);

  localparam int IW  = idw(NREQ);
  localparam int PW  = MBITS + NBITS;
  localparam int WDW = idw(TIMEOUT);
  // Down-counter armed so that it reaches zero in the TIMEOUT-th wait cycle.
  localparam logic [WDW-1:0] WDOG_LOAD = WDW'(TIMEOUT - 1);

  arb_state_e       state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    cur_id_q, cur_id_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic             start_q, start_d;
  logic [MBITS-1:0] mpd_q, mpd_d;
  logic [NBITS-1:0] mpr_q, mpr_d;
  logic [WDW-1:0]   wdog_q, wdog_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [IW-1:0]    rsp_id_q, rsp_id_d;
  logic [PW-1:0]    rsp_prod_q, rsp_prod_d;
  logic             rsp_err_q, rsp_err_d;

  logic [NREQ-1:0]  pick_win;
  logic [IW-1:0]    pick_id;
  logic             pick_any;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .win    (pick_win),
    .win_id (pick_id),
    .any    (pick_any)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cur_id_d    = cur_id_q;
    gnt_d       = '0;
    start_d     = 1'b0;
    mpd_d       = mpd_q;
    mpr_d       = mpr_q;
    wdog_d      = wdog_q;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_prod_d  = rsp_prod_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      IDLE: begin
        if (!mult_busy && pick_any) begin
          gnt_d    = pick_win;
          cur_id_d = pick_id;
          mpd_d    = req_mpd[pick_id*MBITS +: MBITS];
          mpr_d    = req_mpr[pick_id*NBITS +: NBITS];
          ptr_d    = (pick_id == IW'(NREQ - 1)) ? '0 : pick_id + 1'b1;
          state_d  = LAUNCH;
        end
      end
      LAUNCH: begin
        start_d = 1'b1;
        wdog_d  = WDOG_LOAD;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (wdog_q != '0) wdog_d = wdog_q - 1'b1;
        if (mult_busy) begin
          state_d = WAIT_DONE;
        end else if (wdog_q == '0) begin
          rsp_valid_d = 1'b1;
          rsp_id_d    = cur_id_q;
          rsp_prod_d  = '0;
          rsp_err_d   = 1'b1;
          state_d     = RESP;
        end
      end
      WAIT_DONE: begin
        if (wdog_q != '0) wdog_d = wdog_q - 1'b1;
        // A finished product wins over a watchdog expiring in the same cycle.
        if (!mult_busy) begin
          rsp_valid_d = 1'b1;
          rsp_id_d    = cur_id_q;
          rsp_prod_d  = mult_prod;
          rsp_err_d   = 1'b0;
          state_d     = RESP;
        end else if (wdog_q == '0) begin
          rsp_valid_d = 1'b1;
          rsp_id_d    = cur_id_q;
          rsp_prod_d  = '0;
          rsp_err_d   = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      cur_id_q    <= '0;
      gnt_q       <= '0;
      start_q     <= 1'b0;
      mpd_q       <= '0;
      mpr_q       <= '0;
      wdog_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_prod_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cur_id_q    <= cur_id_d;
      gnt_q       <= gnt_d;
      start_q     <= start_d;
      mpd_q       <= mpd_d;
      mpr_q       <= mpr_d;
      wdog_q      <= wdog_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_prod_q  <= rsp_prod_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign gnt        = gnt_q;
  assign mult_start = start_q;
  assign mult_mpd   = mpd_q;
  assign mult_mpr   = mpr_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_prod   = rsp_prod_q;
  assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: behavioural multiplier, round-robin reference model
// and scenario tasks with inline comparisons.
module tb_mult_arbiter;

  localparam int TIMEOUT = 63;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [63:0] req_mpd;
  logic [63:0] req_mpr;
  logic [3:0]  gnt;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [31:0] rsp_prod;
  logic        rsp_err;
  logic [15:0] mult_mpd;
  logic [15:0] mult_mpr;
  logic        mult_start;
  logic        mult_busy = 1'b0;
  logic [31:0] mult_prod = '0;

  mult_arbiter #(.NREQ(4), .MBITS(16), .NBITS(16), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_mpd    (req_mpd),
    .req_mpr    (req_mpr),
    .gnt        (gnt),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_prod   (rsp_prod),
    .rsp_err    (rsp_err),
    .mult_mpd   (mult_mpd),
    .mult_mpr   (mult_mpr),
    .mult_start (mult_start),
    .mult_busy  (mult_busy),
    .mult_prod  (mult_prod)
  );

  always #5 clk = ~clk;

  // Behavioural multiplier: busy for busy_len cycles after a sampled start.
  int busy_len = 4;
  bit tie_low  = 1'b0;
  int busy_cnt = 0;

  always @(posedge clk) begin
    if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1) mult_busy <= 1'b0;
    end else if (mult_start && !tie_low) begin
      mult_busy <= 1'b1;
      busy_cnt  <= busy_len;
      mult_prod <= 32'(int'($signed(mult_mpd)) * int'($signed(mult_mpr)));
    end
  end

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int model_ptr = 0;
  bit auto_drop = 1'b1;
  bit busy_prev = 1'b0;
  int busy_fall_cyc = -1;

  int          g_id[$];
  int          g_cyc[$];
  int          s_cyc[$];
  int          r_id[$];
  int          r_cyc[$];
  logic [31:0] r_prod[$];
  logic        r_err[$];

  function automatic int onehot_id(input logic [3:0] v);
    int r = -1;
    int c = 0;
    for (int i = 0; i < 4; i++) if (v[i]) begin r = i; c++; end
    return (c == 1) ? r : 99;
  endfunction

  function automatic int rr_next(input logic [3:0] pend, input int ptr);
    for (int k = 0; k < 4; k++) begin
      int i = (ptr + k) % 4;
      if (pend[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [31:0] exp_prod(input int slot);
    int a = int'($signed(req_mpd[slot*16 +: 16]));
    int b = int'($signed(req_mpr[slot*16 +: 16]));
    return 32'(a * b);
  endfunction

  task automatic clear_log();
    g_id.delete(); g_cyc.delete(); s_cyc.delete();
    r_id.delete(); r_cyc.delete(); r_prod.delete(); r_err.delete();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (gnt !== 4'b0000) begin
      g_id.push_back(onehot_id(gnt));
      g_cyc.push_back(cyc);
      if (auto_drop) req = req & ~gnt;
    end
    if (mult_start === 1'b1) s_cyc.push_back(cyc);
    if (rsp_valid === 1'b1) begin
      r_id.push_back(int'(rsp_id));
      r_cyc.push_back(cyc);
      r_prod.push_back(rsp_prod);
      r_err.push_back(rsp_err);
    end
    if (busy_prev && !mult_busy) busy_fall_cyc = cyc;
    busy_prev = mult_busy;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    model_ptr = 0;
    clear_log();
  endtask

  task automatic wait_rsp(input string tag, input int n, input int budget);
    int t = 0;
    while (r_id.size() < n && t < budget) begin
      step();
      t++;
    end
    n_cmp++;
    if (r_id.size() < n) begin
      n_bad++;
      $display("FAIL %s_rsp_count: got %0d responses, need %0d", tag, r_id.size(), n);
    end
  endtask

  // Expected service order, products and latency from round-robin rules.
  // Busy-rise detection costs one cycle, so rsp_valid follows gnt by B+3.
  task automatic check_round(input string tag, input logic [3:0] mask, input int blen);
    logic [3:0] pend = mask;
    int n = $countones(mask);
    n_cmp++;
    if (g_id.size() != n) begin
      n_bad++;
      $display("FAIL %s_gnt_count: got %0d grants, need %0d", tag, g_id.size(), n);
    end
    for (int j = 0; j < n; j++) begin
      int e = rr_next(pend, model_ptr);
      pend[e] = 1'b0;
      model_ptr = (e + 1) % 4;
      n_cmp++;
      if (j >= g_id.size() || j >= r_id.size() || j >= s_cyc.size()) begin
        n_bad++;
        $display("FAIL %s_missing[%0d]: grant/start/response not logged for slot %0d", tag, j, e);
        continue;
      end
      if (g_id[j] !== e) begin
        n_bad++; $display("FAIL %s_gnt[%0d]: got slot %0d, need %0d", tag, j, g_id[j], e);
      end
      n_cmp++;
      if (r_id[j] !== e) begin
        n_bad++; $display("FAIL %s_rsp_id[%0d]: got %0d, need %0d", tag, j, r_id[j], e);
      end
      n_cmp++;
      if (r_prod[j] !== exp_prod(e) || r_err[j] !== 1'b0) begin
        n_bad++;
        $display("FAIL %s_prod[%0d]: got %h err %b, need %h err 0", tag, j, r_prod[j], r_err[j], exp_prod(e));
      end
      n_cmp++;
      if (s_cyc[j] - g_cyc[j] != 1) begin
        n_bad++; $display("FAIL %s_start_lag[%0d]: got %0d, need 1", tag, j, s_cyc[j] - g_cyc[j]);
      end
      n_cmp++;
      if (r_cyc[j] - g_cyc[j] != blen + 3) begin
        n_bad++;
        $display("FAIL %s_latency[%0d]: got %0d, need %0d", tag, j, r_cyc[j] - g_cyc[j], blen + 3);
      end
      if (j > 0) begin
        n_cmp++;
        if (g_cyc[j] - r_cyc[j-1] < 2) begin
          n_bad++;
          $display("FAIL %s_idle_gap[%0d]: got %0d, need >=2", tag, j, g_cyc[j] - r_cyc[j-1]);
        end
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    logic [87:0] v;
    v = {gnt, rsp_valid, rsp_id, rsp_prod, rsp_err, mult_start, mult_mpd, mult_mpr};
    n_cmp++;
    if (v !== '0) begin
      n_bad++; $display("FAIL %s_outputs: got %h, need all zero", tag, v);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    check_all_zero("reset");
    do_reset();
    check_all_zero("post_reset");
  endtask

  task automatic test_single();
    do_reset();
    req_mpd = '0; req_mpr = '0;
    req_mpd[15:0] = 16'd10;
    req_mpr[15:0] = 16'hFFF6;
    busy_len = 4; auto_drop = 1'b1;
    req = 4'b0001;
    wait_rsp("single", 1, 60);
    check_round("single", 4'b0001, 4);
    n_cmp++;
    if (r_prod.size() < 1 || r_prod[0] !== 32'hFFFFFF9C) begin
      n_bad++; $display("FAIL single_const: got %h, need ffffff9c", (r_prod.size() > 0) ? r_prod[0] : 32'hx);
    end
    step();
    n_cmp++;
    if (mult_mpd !== 16'd10 || mult_mpr !== 16'hFFF6) begin
      n_bad++; $display("FAIL single_hold: got %h/%h, need 000a/fff6", mult_mpd, mult_mpr);
    end
  endtask

  task automatic test_all_four();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req_mpd[i*16 +: 16] = 16'(i + 1);
      req_mpr[i*16 +: 16] = 16'd10;
    end
    busy_len = 3; auto_drop = 1'b1;
    req = 4'b1111;
    wait_rsp("all4", 4, 200);
    check_round("all4", 4'b1111, 3);
    for (int i = 0; i < 4 && i < r_prod.size(); i++) begin
      n_cmp++;
      if (r_prod[i] !== 32'((i + 1) * 10)) begin
        n_bad++; $display("FAIL all4_const[%0d]: got %0d, need %0d", i, r_prod[i], (i + 1) * 10);
      end
    end
  endtask

  task automatic test_pointer();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req_mpd[i*16 +: 16] = 16'($urandom);
      req_mpr[i*16 +: 16] = 16'($urandom);
    end
    busy_len = 2; auto_drop = 1'b1;
    req = 4'b0010;
    wait_rsp("ptr_a", 1, 60);
    check_round("ptr_a", 4'b0010, 2);
    clear_log();
    req = 4'b1001;
    wait_rsp("ptr_b", 2, 100);
    check_round("ptr_b", 4'b1001, 2);
    n_cmp++;
    if (g_id.size() < 1 || g_id[0] !== 3) begin
      n_bad++; $display("FAIL ptr_first: got slot %0d, need 3", (g_id.size() > 0) ? g_id[0] : -1);
    end
  endtask

  task automatic test_timeout();
    tie_low = 1'b1;
    clear_log();
    auto_drop = 1'b1;
    req = 4'b0100;
    wait_rsp("tmo", 1, TIMEOUT + 20);
    n_cmp++;
    if (r_id.size() < 1 || g_cyc.size() < 1) begin
      n_bad++; $display("FAIL tmo_seen: got no grant/response, need one each");
    end else begin
      if (r_err[0] !== 1'b1 || r_prod[0] !== 32'd0 || r_id[0] !== 2) begin
        n_bad++;
        $display("FAIL tmo_fields: got err %b prod %h id %0d, need err 1 prod 0 id 2", r_err[0], r_prod[0], r_id[0]);
      end
      n_cmp++;
      if (r_cyc[0] - g_cyc[0] != TIMEOUT + 1) begin
        n_bad++; $display("FAIL tmo_latency: got %0d, need %0d", r_cyc[0] - g_cyc[0], TIMEOUT + 1);
      end
    end
    model_ptr = 3;
    tie_low = 1'b0;
    clear_log();
    req_mpd[0 +: 16] = 16'h8000;
    req_mpr[0 +: 16] = 16'h8000;
    busy_len = 5;
    req = 4'b0001;
    wait_rsp("tmo_next", 1, 60);
    check_round("tmo_next", 4'b0001, 5);
  endtask

  task automatic test_reset_mid();
    int t;
    do_reset();
    req_mpd[16 +: 16] = 16'hFED4;
    req_mpr[16 +: 16] = 16'd77;
    busy_len = 7; auto_drop = 1'b0;
    req = 4'b0010;
    t = 0;
    while (g_id.size() == 0 && t < 50) begin step(); t++; end
    t = 0;
    while (!mult_busy && t < 20) begin step(); t++; end
    step();
    step();
    n_cmp++;
    if (mult_busy !== 1'b1) begin
      n_bad++; $display("FAIL rmid_setup: mult_busy got %b, need 1", mult_busy);
    end
    rst_n = 1'b0;
    #1;
    check_all_zero("rmid_async");
    step();
    rst_n = 1'b1;
    model_ptr = 0;
    clear_log();
    busy_fall_cyc = -1;
    busy_len = 3;
    t = 0;
    while (g_id.size() == 0 && t < 50) begin
      step();
      t++;
      n_cmp++;
      if (gnt !== 4'b0000 && busy_prev && busy_fall_cyc < 0) begin
        n_bad++; $display("FAIL rmid_busy_gnt: got gnt %b while mult busy, need 0000", gnt);
      end
    end
    req = 4'b0000;
    n_cmp++;
    if (g_cyc.size() < 1 || g_cyc[0] != busy_fall_cyc + 1) begin
      n_bad++;
      $display("FAIL rmid_gnt_time: got cycle %0d, need %0d", (g_cyc.size() > 0) ? g_cyc[0] : -1, busy_fall_cyc + 1);
    end
    wait_rsp("rmid", 1, 60);
    check_round("rmid", 4'b0010, 3);
    auto_drop = 1'b1;
  endtask

  task automatic test_drop();
    do_reset();
    busy_len = 4; auto_drop = 1'b1;
    req = 4'b0110;
    wait_rsp("drop", 1, 60);
    req[2] = 1'b0;
    for (int i = 0; i < 12; i++) step();
    n_cmp++;
    if (g_id.size() != 1 || g_id[0] !== 1) begin
      n_bad++; $display("FAIL drop_gnt: got %0d grants, need exactly one to slot 1", g_id.size());
    end
    n_cmp++;
    if (s_cyc.size() != 1) begin
      n_bad++; $display("FAIL drop_start: got %0d starts, need 1", s_cyc.size());
    end
  endtask

  task automatic test_random();
    do_reset();
    auto_drop = 1'b1;
    for (int r = 0; r < 8; r++) begin
      logic [3:0] mask = 4'($urandom_range(1, 15));
      int blen = $urandom_range(1, 8);
      for (int i = 0; i < 4; i++) begin
        req_mpd[i*16 +: 16] = 16'($urandom);
        req_mpr[i*16 +: 16] = 16'($urandom);
      end
      busy_len = blen;
      clear_log();
      req = mask;
      wait_rsp($sformatf("rand%0d", r), $countones(mask), 40 * $countones(mask));
      check_round($sformatf("rand%0d", r), mask, blen);
    end
  endtask

  initial begin
    req = '0;
    req_mpd = '0;
    req_mpr = '0;
    test_reset();
    test_single();
    test_all_four();
    test_pointer();
    test_timeout();
    test_reset_mid();
    test_drop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, need completion");
    $fatal(1);
  end

endmodule
